// File: rtl/out_data_rx.sv
// out_data_rx: receive-side data stage feeding the OUT FIFO.
// Checks toggle and CRC16, withholds the CRC bytes, drives the FIFO handshake.
module out_data_rx #(
   parameter int OUT_MAXPACKETSIZE = 8
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       clk_gate_i,
   input  logic       pkt_start_i,
   input  logic       pid_data1_i,
   input  logic       toggle_clr_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   input  logic       rx_eop_i,
   input  logic       rx_err_i,
   output logic [7:0] out_data_o,
   output logic       out_valid_o,
   output logic       out_err_o,
   output logic       out_ready_o,
   input  logic       out_nak_i,
   output logic       done_o,
   output logic [1:0] status_o,
   output logic       crc_err_o
);

   localparam int            CW       = $clog2(OUT_MAXPACKETSIZE + 1);
   localparam logic [CW-1:0] MAXC     = CW'(OUT_MAXPACKETSIZE);
   localparam logic [15:0]   CRC_INIT = 16'hFFFF;
   localparam logic [15:0]   CRC_RES  = 16'hB001;
   localparam logic [1:0]    ST_NONE  = 2'b00;
   localparam logic [1:0]    ST_ACK   = 2'b01;
   localparam logic [1:0]    ST_NAK   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX0,
      S_RX1,
      S_RXN,
      S_ABORT,
      S_COMMIT
   } state_t;

   state_t        r_state;
   logic [7:0]    r_old;
   logic [7:0]    r_new;
   logic [15:0]   r_crc;
   logic [CW-1:0] r_cnt;
   logic          r_toggle;
   logic          r_mismatch;
   logic          r_nak;
   logic          r_crc_bad;
   logic          r_restart;
   logic          r_restart_pid;

   logic [15:0]   w_crc_nxt;
   logic          w_tgl;

   function automatic logic [15:0] f_crc(input logic [15:0] c,
                                         input logic [7:0]  d);
      logic [15:0] x;
      x = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
      end
      return x;
   endfunction

   assign w_crc_nxt = f_crc(r_crc, rx_data_i);
   // a same-cycle clear already counts when judging the incoming PID
   assign w_tgl     = toggle_clr_i ? 1'b0 : r_toggle;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state       <= S_IDLE;
         r_old         <= 8'h00;
         r_new         <= 8'h00;
         r_crc         <= CRC_INIT;
         r_cnt         <= '0;
         r_toggle      <= 1'b0;
         r_mismatch    <= 1'b0;
         r_nak         <= 1'b0;
         r_crc_bad     <= 1'b0;
         r_restart     <= 1'b0;
         r_restart_pid <= 1'b0;
         out_data_o    <= 8'h00;
         out_valid_o   <= 1'b0;
         out_err_o     <= 1'b0;
         out_ready_o   <= 1'b0;
         done_o        <= 1'b0;
         status_o      <= ST_NONE;
         crc_err_o     <= 1'b0;
      end else if (clk_gate_i) begin
         out_data_o  <= 8'h00;
         out_valid_o <= 1'b0;
         out_err_o   <= 1'b0;
         out_ready_o <= 1'b0;
         done_o      <= 1'b0;
         status_o    <= ST_NONE;
         crc_err_o   <= 1'b0;
         if (toggle_clr_i) begin
            r_toggle <= 1'b0;
         end
         unique case (r_state)
            S_IDLE: begin
               if (pkt_start_i) begin
                  r_state    <= S_RX0;
                  r_mismatch <= (pid_data1_i != w_tgl);
                  r_crc      <= CRC_INIT;
                  r_cnt      <= '0;
               end
            end
            S_RX0, S_RX1, S_RXN: begin
               r_crc_bad <= 1'b0;
               r_restart <= 1'b0;
               if (rx_err_i) begin
                  r_state     <= S_ABORT;
                  out_err_o   <= 1'b1;
                  out_ready_o <= 1'b1;
               end else if (pkt_start_i) begin
                  r_state       <= S_ABORT;
                  out_err_o     <= 1'b1;
                  out_ready_o   <= 1'b1;
                  r_restart     <= 1'b1;
                  r_restart_pid <= pid_data1_i;
               end else if (rx_eop_i) begin
                  if (r_state != S_RXN || r_crc != CRC_RES) begin
                     r_state     <= S_ABORT;
                     out_err_o   <= 1'b1;
                     out_ready_o <= 1'b1;
                     r_crc_bad   <= (r_state == S_RXN);
                  end else begin
                     // nak is judged now, ahead of the commit strobe
                     r_state     <= S_COMMIT;
                     r_nak       <= out_nak_i;
                     out_ready_o <= ~r_mismatch;
                  end
               end else if (rx_valid_i) begin
                  r_crc <= w_crc_nxt;
                  r_old <= r_new;
                  r_new <= rx_data_i;
                  if (r_state == S_RX0) begin
                     r_state <= S_RX1;
                  end else if (r_state == S_RX1) begin
                     r_state <= S_RXN;
                  end else if (r_cnt == MAXC) begin
                     r_state     <= S_ABORT;
                     out_err_o   <= 1'b1;
                     out_ready_o <= 1'b1;
                  end else begin
                     r_cnt       <= r_cnt + CW'(1);
                     out_data_o  <= r_mismatch ? 8'h00 : r_old;
                     out_valid_o <= ~r_mismatch;
                     out_ready_o <= ~r_mismatch;
                  end
               end
            end
            S_ABORT: begin
               done_o    <= 1'b1;
               status_o  <= ST_NONE;
               crc_err_o <= r_crc_bad;
               if (r_restart) begin
                  r_state    <= S_RX0;
                  r_mismatch <= (r_restart_pid != w_tgl);
                  r_crc      <= CRC_INIT;
                  r_cnt      <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_COMMIT: begin
               done_o  <= 1'b1;
               r_state <= S_IDLE;
               if (r_mismatch) begin
                  status_o <= ST_ACK;
               end else if (r_nak) begin
                  status_o <= ST_NAK;
               end else begin
                  status_o <= ST_ACK;
                  r_toggle <= toggle_clr_i ? 1'b0 : ~r_toggle;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
